// File: rtl/counter_ctrl_if.sv
// counter_ctrl_if: command channel into counter_ctrl (valid/ready handshake plus
// the operands a command carries).
interface counter_ctrl_if #(
    parameter int PRESC_W = 8,
    parameter int LEN_W = 8
);
    logic cmd_valid;
    logic cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data;
    logic [LEN_W-1:0] cmd_len;
    logic [PRESC_W-1:0] presc;
    modport master (output cmd_valid, cmd_op, cmd_data, cmd_len, presc, input cmd_ready);
    modport slave (input cmd_valid, cmd_op, cmd_data, cmd_len, presc, output cmd_ready);
endinterface

// File: rtl/counter_ctrl.sv
// counter_ctrl: command sequencer driving a mod-4 counter's enb/modo/data with
// prescaled, length-limited stepping and a saturating wrap count from Q feedback.
module counter_ctrl #(
    parameter int PRESC_W = 8,
    parameter int LEN_W = 8,
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    counter_ctrl_if.slave     cmd,
    input  logic [3:0]        q_in,
    output logic              enb,
    output logic              modo,
    output logic [3:0]        data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [WRAP_W-1:0] wrap_cnt
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    localparam logic [1:0] OP_LOAD = 2'd1, OP_RUN = 2'd2, OP_STOP = 2'd3;
    state_t state, nxt;
    logic [PRESC_W-1:0] pre, pre_d, pre_rl, pre_rl_d;
    logic [LEN_W-1:0] rem, rem_d;
    logic [3:0] data_d;
    logic [WRAP_W-1:0] wrap_d;
    logic enb_d, modo_d, busy_d, done_d, err_d;
    logic acc, step, do_load, do_run;

    assign cmd.cmd_ready = state == IDLE || state == RUN;
    assign acc = cmd.cmd_valid && cmd.cmd_ready;
    assign do_load = state == IDLE && acc && cmd.cmd_op == OP_LOAD;
    assign do_run = state == IDLE && acc && cmd.cmd_op == OP_RUN;
    assign step = state == RUN && pre == '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            pre      <= '0;
            pre_rl   <= '0;
            rem      <= '0;
            enb      <= 1'b0;
            modo     <= 1'b0;
            data     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            wrap_cnt <= '0;
        end else begin
            state    <= nxt;
            pre      <= pre_d;
            pre_rl   <= pre_rl_d;
            rem      <= rem_d;
            enb      <= enb_d;
            modo     <= modo_d;
            data     <= data_d;
            busy     <= busy_d;
            done     <= done_d;
            err      <= err_d;
            wrap_cnt <= wrap_d;
        end
    end

    // STOP takes priority over completion when both land on the same edge
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = do_load ? LOAD : do_run ? RUN : IDLE;
            RUN:     nxt = (acc && cmd.cmd_op == OP_STOP) ? IDLE
                         : (step && rem == LEN_W'(1)) ? DONE : RUN;
            default: nxt = IDLE;
        endcase
    end

    // rem == 0 in RUN means free-run, so it is never decremented there
    always_comb begin
        enb_d    = do_load || step;
        modo_d   = do_load;
        data_d   = do_load ? cmd.cmd_data : data;
        pre_rl_d = do_run ? cmd.presc : pre_rl;
        pre_d    = do_run ? cmd.presc : step ? pre_rl : state == RUN ? pre - PRESC_W'(1) : pre;
        rem_d    = do_run ? cmd.cmd_len : (step && rem != '0) ? rem - LEN_W'(1) : rem;
        busy_d   = nxt != IDLE;
        done_d   = state == DONE;
        err_d    = acc && ((state == IDLE) == (cmd.cmd_op == OP_STOP));
        wrap_d   = do_load ? '0
                 : (enb && !modo && q_in == 4'd3 && wrap_cnt != '1) ? wrap_cnt + WRAP_W'(1)
                 : wrap_cnt;
    end
endmodule
